flap_input_ctrl: RTL
====================

Name: flap_input_ctrl

Overview:
- Turns the debounced button levels (flap, start, pause) into frame-aligned game commands.
- Owns the game-mode state machine: idle, playing, paused, game over.
- Sits between the per-button debouncers and the game core, and is the only block that issues start, flap and pause commands.
- Commands are released only on frame boundaries, so the physics update sees at most one flap per frame.

Parameters:
- HOLD_FRAMES, 20: frames flap must be held in PLAY before auto-repeat begins.
- REPEAT_FRAMES, 8: frame interval between auto-repeat flaps once repeat is active.
- LOCKOUT_FRAMES, 30: frames after entering OVER during which all button input is ignored.
- CNT_W, 6: width of the frame counters; must hold max(HOLD_FRAMES, REPEAT_FRAMES, LOCKOUT_FRAMES).

Ports:
- clk  in  1  system clock (100 MHz).
- rst  in  1  asynchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse per video frame.
- flap_lvl  in  1  debounced flap button level.
- start_lvl  in  1  debounced start button level.
- pause_lvl  in  1  debounced pause button level.
- game_over  in  1  level from game core; high when a collision has occurred.
- cmd_start  out  1  one-cycle pulse: begin a new game.
- cmd_flap  out  1  one-cycle pulse: apply flap impulse.
- cmd_reset  out  1  one-cycle pulse: clear the playfield back to idle.
- paused  out  1  level, high while in PAUSE.
- mode  out  2  current state: 0 IDLE, 1 PLAY, 2 PAUSE, 3 OVER.

Behaviour:
- Reset (async, rst=1):
  - mode=IDLE; all cmd_* outputs 0; paused=0.
  - All pending flags, edge registers and counters cleared.
  - Edge registers reset to 0, so a button already held at reset release counts as one rising edge.
- Edge capture, per button:
  - Rising edge = level high while the previous-cycle level was low.
  - A rising edge sets a sticky pending flag.
  - Pending flags are consumed or discarded only on frame_tick cycles.
  - An edge in the same cycle as frame_tick is seen by that tick (pending OR current edge).
  - Multiple edges within one frame collapse into one.
- Decisions and timing:
  - All state transitions and commands are decided only when frame_tick=1.
  - Command outputs are registered and pulse in the cycle after frame_tick, so latency from frame_tick is 1 cycle.
  - At most one cmd_* pulse per frame; all pending flags are cleared on every frame_tick regardless of state.
  - frame_tick held high continuously is treated as one tick per cycle.
- IDLE:
  - start or flap pending -> PLAY, pulse cmd_start; that flap is not also emitted as cmd_flap.
  - pause pending is ignored.
- PLAY, priority order:
  - game_over=1 -> OVER; lockout counter loaded with LOCKOUT_FRAMES.
  - else pause pending -> PAUSE, flap discarded.
  - else flap pending or auto-repeat due -> pulse cmd_flap.
  - start pending is ignored.
- PAUSE:
  - paused=1.
  - pause or start pending -> PLAY.
  - flap discarded; game_over ignored until back in PLAY.
- OVER:
  - Lockout counter decrements per tick; all pendings discarded while it is nonzero.
  - At zero, start or flap pending -> IDLE with a cmd_reset pulse.
- Auto-repeat:
  - Hold counter increments per frame_tick while mode=PLAY and flap_lvl=1, saturating at its maximum.
  - Repeat flap is due when the counter equals HOLD_FRAMES, then every REPEAT_FRAMES frames after that.
  - Counter clears on flap release or on leaving PLAY.
- Reset asserted mid-frame or mid-command: outputs drop immediately (async); no command is replayed after release.

Decomposition:
- Shared package (flappy_pkg):
  - mode encoding constants IDLE/PLAY/PAUSE/OVER.
  - Default frame-count constants.
- One natural sub-module, btn_edge_latch: rising-edge detect plus sticky pending flag with a clear input, instantiated three times.

Test Plan:
- Reset, then flap edge 5 cycles before frame_tick -> cmd_start 1 cycle after tick, no cmd_flap, mode=1.
- In PLAY, three flap edges within one frame -> exactly one cmd_flap, 1 cycle after the next tick.
- In PLAY, hold flap for 40 frames -> cmd_flap on frame 0 (edge), then on frames 20, 28 and 36 (auto-repeat).
- In PLAY, pause and flap edges in the same frame -> mode=2, paused=1, no cmd_flap. Pause again -> mode=1.
- game_over=1 at a tick -> mode=3. Start pressed at tick 10 is ignored. Start at tick 31 -> cmd_reset, mode=0.
- rst pulsed while the hold counter is at 15 and a flap is pending -> outputs 0 immediately. After release, no cmd_flap and mode=0.

Source files
------------

// File: rtl/flappy_pkg.sv
// Shared mode encoding and default frame counts for the flappy input path.
package flappy_pkg;

  localparam logic [1:0] MODE_IDLE  = 2'd0;
  localparam logic [1:0] MODE_PLAY  = 2'd1;
  localparam logic [1:0] MODE_PAUSE = 2'd2;
  localparam logic [1:0] MODE_OVER  = 2'd3;

  localparam int unsigned HOLD_FRAMES_DEF    = 20;
  localparam int unsigned REPEAT_FRAMES_DEF  = 8;
  localparam int unsigned LOCKOUT_FRAMES_DEF = 30;
  localparam int unsigned CNT_W_DEF          = 6;

  // Pending button requests as seen on a frame boundary.
  typedef struct packed {
    logic flap;
    logic start;
    logic pause;
  } btn_pend_t;

endpackage

// File: rtl/btn_edge_latch.sv
// Rising-edge detector with a sticky pending flag, cleared on frame boundaries.
module btn_edge_latch (
  input  logic clk,
  input  logic rst,
  input  logic lvl,
  input  logic clr,
  output logic pend_c
);

  logic lvl_q;
  logic pend_q;
  logic rise_c;

  assign rise_c = lvl & ~lvl_q;
  // An edge coinciding with clr is visible to that frame boundary.
  assign pend_c = pend_q | rise_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lvl_q  <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      lvl_q  <= lvl;
      pend_q <= clr ? 1'b0 : pend_c;
    end
  end

endmodule

// File: rtl/flap_input_ctrl.sv
// Game-mode FSM turning debounced buttons into frame-aligned start/flap/reset commands.
module flap_input_ctrl
  import flappy_pkg::*;
#(
  parameter int unsigned HOLD_FRAMES    = HOLD_FRAMES_DEF,
  parameter int unsigned REPEAT_FRAMES  = REPEAT_FRAMES_DEF,
  parameter int unsigned LOCKOUT_FRAMES = LOCKOUT_FRAMES_DEF,
  parameter int unsigned CNT_W          = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       flap_lvl,
  input  logic       start_lvl,
  input  logic       pause_lvl,
  input  logic       game_over,
  output logic       cmd_start,
  output logic       cmd_flap,
  output logic       cmd_reset,
  output logic       paused,
  output logic [1:0] mode
);

  localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(HOLD_FRAMES);
  localparam logic [CNT_W-1:0] REP_C  = CNT_W'(REPEAT_FRAMES);
  localparam logic [CNT_W-1:0] LOCK_C = CNT_W'(LOCKOUT_FRAMES);

  btn_pend_t        pend_c;
  logic [1:0]       mode_nxt;
  logic             start_nxt;
  logic             flap_nxt;
  logic             reset_nxt;
  logic [CNT_W-1:0] lock_cnt;
  logic [CNT_W-1:0] lock_nxt;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] rep_cnt;
  logic             rep_due_c;

  btn_edge_latch u_flap  (.clk(clk), .rst(rst), .lvl(flap_lvl),  .clr(frame_tick), .pend_c(pend_c.flap));
  btn_edge_latch u_start (.clk(clk), .rst(rst), .lvl(start_lvl), .clr(frame_tick), .pend_c(pend_c.start));
  btn_edge_latch u_pause (.clk(clk), .rst(rst), .lvl(pause_lvl), .clr(frame_tick), .pend_c(pend_c.pause));

  // First repeat at HOLD_FRAMES, then every REPEAT_FRAMES while still held.
  assign rep_due_c = (hold_cnt == HOLD_C) | ((hold_cnt > HOLD_C) & (rep_cnt == REP_C));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= '0;
      rep_cnt  <= '0;
    end else if (!flap_lvl || mode != MODE_PLAY) begin
      hold_cnt <= '0;
      rep_cnt  <= '0;
    end else if (frame_tick) begin
      if (hold_cnt != '1) hold_cnt <= hold_cnt + 1'b1;
      if (rep_due_c)               rep_cnt <= CNT_W'(1);
      else if (hold_cnt > HOLD_C)  rep_cnt <= rep_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode      <= MODE_IDLE;
      cmd_start <= 1'b0;
      cmd_flap  <= 1'b0;
      cmd_reset <= 1'b0;
      paused    <= 1'b0;
      lock_cnt  <= '0;
    end else begin
      mode      <= mode_nxt;
      cmd_start <= start_nxt;
      cmd_flap  <= flap_nxt;
      cmd_reset <= reset_nxt;
      paused    <= (mode_nxt == MODE_PAUSE);
      lock_cnt  <= lock_nxt;
    end
  end

  always_comb begin
    mode_nxt  = mode;
    start_nxt = 1'b0;
    flap_nxt  = 1'b0;
    reset_nxt = 1'b0;
    lock_nxt  = lock_cnt;
    if (frame_tick) begin
      case (mode)
        MODE_IDLE: begin
          if (pend_c.start || pend_c.flap) begin
            mode_nxt  = MODE_PLAY;
            start_nxt = 1'b1;
          end
        end
        MODE_PLAY: begin
          if (game_over) begin
            mode_nxt = MODE_OVER;
            lock_nxt = LOCK_C;
          end else if (pend_c.pause) begin
            mode_nxt = MODE_PAUSE;
          end else if (pend_c.flap || rep_due_c) begin
            flap_nxt = 1'b1;
          end
        end
        MODE_PAUSE: begin
          if (pend_c.pause || pend_c.start) mode_nxt = MODE_PLAY;
        end
        MODE_OVER: begin
          if (lock_cnt != '0) begin
            lock_nxt = lock_cnt - 1'b1;
          end else if (pend_c.start || pend_c.flap) begin
            mode_nxt  = MODE_IDLE;
            reset_nxt = 1'b1;
          end
        end
        default: mode_nxt = MODE_IDLE;
      endcase
    end
  end

endmodule
